round_const_seq: RTL

//  Parametrised round-constant sequencer for the hash datapath.
//  - On start, snapshots a packed table of NUM_WORDS constants.
//  - Streams the constants one per accepted beat over a valid/ready handshake,

---
 rtl/round_const_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/round_const_seq.sv
// Round-constant sequencer: snapshots a packed table of constants on start and
// streams them one per accepted beat (valid/ready), ascending or descending.
// Word 0 sits in the most-significant WORD_W bits of K_in.
module round_const_seq #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        dir,
    input  logic [WORD_W*NUM_WORDS-1:0] K_in,
    input  logic                        kout_ready,
    output logic                        kout_valid,
    output logic [WORD_W-1:0]           kout,
    output logic [IDX_W-1:0]            kidx,
    output logic                        busy,
    output logic                        done
);

    localparam logic [IDX_W-1:0] LastUp = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e                      state_q, state_d;
    logic [WORD_W*NUM_WORDS-1:0] snap_q, snap_d;
    logic                        dir_q, dir_d;
    logic [IDX_W-1:0]            idx_q, idx_d, idx_step;
    logic [WORD_W-1:0]           kout_q, kout_d;
    logic [IDX_W-1:0]            kidx_q, kidx_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        beat;
    logic                        last;
    logic [WORD_W-1:0]           words [NUM_WORDS];

    // Unpack the snapshot so word 0 comes from the top bits.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        assign words[gi] = snap_q[WORD_W*(NUM_WORDS-gi)-1 -: WORD_W];
    end

    assign beat     = valid_q & kout_ready;
    // Last word is detected against fixed end indices, so idx never steps past either end.
    assign last     = dir_q ? (idx_q == '0) : (idx_q == LastUp);
    assign idx_step = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one cycle in LOAD and DONE, RUN until the last word is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (beat && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next values; start is only honoured in IDLE.
    always_comb begin
        snap_d  = snap_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        kout_d  = kout_q;
        kidx_d  = kidx_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d = K_in;
                    dir_d  = dir;
                    idx_d  = dir ? LastUp : '0;
                end
            end
            StLoad: begin
                kout_d  = words[idx_q];
                kidx_d  = idx_q;
                valid_d = 1'b1;
            end
            StRun: begin
                if (beat) begin
                    if (last) begin
                        valid_d = 1'b0;
                    end else begin
                        idx_d  = idx_step;
                        kout_d = words[idx_step];
                        kidx_d = idx_step;
                    end
                end
            end
            StDone: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q  <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            kout_q  <= '0;
            kidx_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            kout_q  <= kout_d;
            kidx_q  <= kidx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign kout_valid = valid_q;
    assign kout       = kout_q;
    assign kidx       = kidx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
